// File: rtl/sha3_sponge_ctrl.sv
// ============================================================================
// Module  : sha3_sponge_ctrl
// Purpose : SHA-3 sponge sequencer: absorbs rate blocks, runs 24 Keccak-f
//           rounds per block, holds the digest and checks the RC counter sync.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sha3_sponge_ctrl #(
  parameter int BLOCK_CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   A_RST,
  input  logic                   BLOCK_VALID,
  input  logic                   BLOCK_LAST,
  output logic                   BLOCK_READY,
  output logic                   RC_CE,
  output logic                   RC_COUNTER_RESET,
  input  logic                   RC_WAIT,
  output logic                   STATE_CLEAR,
  output logic                   ABSORB_EN,
  output logic                   ROUND_EN,
  output logic [4:0]             ROUND_IDX,
  output logic [BLOCK_CNT_W-1:0] MSG_BLOCK_CNT,
  output logic                   DIGEST_VALID,
  input  logic                   DIGEST_READY,
  output logic                   SYNC_ERR
);

  localparam logic [4:0]             C_LAST_ROUND = 5'd23;
  localparam logic [BLOCK_CNT_W-1:0] C_CNT_MAX    = {BLOCK_CNT_W{1'b1}};
  localparam logic [BLOCK_CNT_W-1:0] C_CNT_ONE    = BLOCK_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ROUNDS  = 2'd1,
    S_SQUEEZE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [4:0]             r_round_idx;
  logic [BLOCK_CNT_W-1:0] r_blk_cnt;
  logic                   r_first_block;
  logic                   r_last_flag;
  logic                   r_left_rounds;
  logic                   r_sync_err;

  logic w_in_idle;
  logic w_in_rounds;
  logic w_in_squeeze;
  logic w_accept;
  logic w_last_round;
  logic w_handoff;
  logic w_sync_fault;

  assign w_in_idle    = (r_state == S_IDLE);
  assign w_in_rounds  = (r_state == S_ROUNDS);
  assign w_in_squeeze = (r_state == S_SQUEEZE);

  // Reset gates the accept path so no strobe can fire while A_RST is high.
  assign BLOCK_READY  = w_in_idle & ~r_sync_err;
  assign w_accept     = BLOCK_VALID & BLOCK_READY & ~A_RST;
  assign w_last_round = w_in_rounds & (r_round_idx == C_LAST_ROUND);
  assign w_handoff    = w_in_squeeze & DIGEST_READY;

  assign ABSORB_EN        = w_accept;
  assign RC_COUNTER_RESET = w_accept;
  assign STATE_CLEAR      = w_accept & r_first_block;
  assign ROUND_EN         = w_in_rounds;
  assign RC_CE            = w_accept | w_in_rounds;
  assign ROUND_IDX        = r_round_idx;
  assign MSG_BLOCK_CNT    = r_blk_cnt;
  assign DIGEST_VALID     = w_in_squeeze;
  assign SYNC_ERR         = r_sync_err;

  // Round 0 is the cycle right after the counter restart, so WAIT may still
  // be settling there; from round 1 on it must be low, and high once done.
  assign w_sync_fault = (w_in_rounds & (r_round_idx != 5'd0) & RC_WAIT) |
                        (r_left_rounds & ~RC_WAIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_ROUNDS;
        end
      end
      S_ROUNDS: begin
        if (w_last_round) begin
          w_next = r_last_flag ? S_SQUEEZE : S_IDLE;
        end
      end
      S_SQUEEZE: begin
        if (DIGEST_READY) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge A_RST) begin
    if (A_RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or posedge A_RST) begin
    if (A_RST) begin
      r_round_idx   <= 5'd0;
      r_left_rounds <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      if (w_accept || w_last_round) begin
        r_round_idx <= 5'd0;
      end else if (w_in_rounds) begin
        r_round_idx <= r_round_idx + 5'd1;
      end
      r_left_rounds <= w_last_round;
      if (w_sync_fault) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge A_RST) begin
    if (A_RST) begin
      r_blk_cnt     <= '0;
      r_first_block <= 1'b1;
      r_last_flag   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_first_block <= 1'b0;
        r_last_flag   <= BLOCK_LAST;
        if (r_first_block) begin
          r_blk_cnt <= C_CNT_ONE;
        end else if (r_blk_cnt != C_CNT_MAX) begin
          r_blk_cnt <= r_blk_cnt + C_CNT_ONE;
        end
      end else if (w_handoff) begin
        r_first_block <= 1'b1;
        r_last_flag   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha3_sponge_ctrl.sv
// ============================================================================
// Module  : tb_sha3_sponge_ctrl
// Purpose : Scoreboard bench for sha3_sponge_ctrl with a behavioural RC counter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sha3_sponge_ctrl;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bv = 1'b0, bl = 1'b0, dr = 1'b0;
  logic          b_ready, rc_ce, rc_rst, rc_wait, st_clr, absorb, round_en;
  logic [4:0]    ridx;
  logic [CW-1:0] bcnt;
  logic          dv, serr;
  logic          force_wait = 1'b0;
  logic [4:0]    rc_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    bit       kind;   // 0 = accept, 1 = digest handoff
    bit       clear;
    bit [1:0] cnt;
    bit       serr;
  } exp_t;
  exp_t sb[$];
  bit   exp_first = 1'b1;

  sha3_sponge_ctrl #(.BLOCK_CNT_W(CW)) dut (
    .CLK(clk), .A_RST(rst),
    .BLOCK_VALID(bv), .BLOCK_LAST(bl), .BLOCK_READY(b_ready),
    .RC_CE(rc_ce), .RC_COUNTER_RESET(rc_rst), .RC_WAIT(rc_wait),
    .STATE_CLEAR(st_clr), .ABSORB_EN(absorb), .ROUND_EN(round_en),
    .ROUND_IDX(ridx), .MSG_BLOCK_CNT(bcnt),
    .DIGEST_VALID(dv), .DIGEST_READY(dr), .SYNC_ERR(serr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-constant counter: restart to 0, count 24 enabled rounds, then wait.
  always @(posedge clk or posedge rst) begin
    if (rst) rc_cnt <= 5'd24;
    else if (rc_ce) begin
      if (rc_rst) rc_cnt <= 5'd0;
      else if (rc_cnt < 5'd24) rc_cnt <= rc_cnt + 5'd1;
    end
  end
  assign rc_wait = force_wait | (rc_cnt == 5'd24);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries on accepts and digest handoffs.
  int acc_cyc = 0;
  bit prev_nonlast = 0, prev_dv = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_nonlast = 0;
      prev_dv = 0;
    end else begin
      if (absorb) begin
        exp_t e;
        if (sb.size() == 0) chk("unexpected_accept", 1, 0);
        else begin
          e = sb.pop_front();
          chk("accept_kind", e.kind, 0);
          chk("state_clear", st_clr, e.clear);
          chk("rc_reset_on_accept", {rc_rst, rc_ce}, 2'b11);
        end
        if (prev_nonlast) chk("accept_spacing", cyc - acc_cyc, 25);
        acc_cyc = cyc;
        prev_nonlast = !bl;
      end
      if (round_en) chk("round_idx", ridx, cyc - acc_cyc - 1);
      if (dv && !prev_dv) chk("digest_latency", cyc - acc_cyc, 25);
      if (dv && dr) begin
        exp_t e;
        if (sb.size() == 0) chk("unexpected_digest", 1, 0);
        else begin
          e = sb.pop_front();
          chk("digest_kind", e.kind, 1);
          chk("msg_block_cnt", bcnt, e.cnt);
          chk("sync_err_at_digest", serr, e.serr);
        end
        prev_nonlast = 0;
      end
      prev_dv = dv;
    end
  end

  task automatic wait_accept();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (absorb) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_dv();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dv) return;
    end
    chk("digest_timeout", 0, 1);
  endtask

  task automatic send_msg(input int n, input int bp, input bit serr_exp, input int fault);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{kind: 1'b0, clear: (i == 0) ? exp_first : 1'b0, cnt: 2'd0, serr: 1'b0};
      sb.push_back(e);
    end
    e = '{kind: 1'b1, clear: 1'b0, cnt: (n > 3) ? 2'd3 : 2'(n), serr: serr_exp};
    sb.push_back(e);
    exp_first = 1'b1;
    @(posedge clk); #1;
    bv = 1'b1;
    bl = (n == 1);
    for (int i = 0; i < n; i++) begin
      wait_accept();
      @(posedge clk); #1;
      bl = (i + 1 == n - 1);
      if (i == n - 1) bv = 1'b0;
    end
    if (fault >= 0) begin
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (round_en && ridx == 5'(fault)) break;
      end
      force_wait = 1'b1;
      @(posedge clk); #1;
      force_wait = 1'b0;
      @(negedge clk);
      chk("sync_err_set", serr, 1);
    end
    wait_dv();
    for (int j = 0; j < bp; j++) begin
      @(posedge clk); #1;
      bv = 1'b1;
      @(negedge clk);
      chk("bp_digest_valid", dv, 1);
      chk("bp_block_ready", b_ready, 0);
    end
    @(posedge clk); #1;
    bv = 1'b0;
    dr = 1'b1;
    @(posedge clk); #1;
    dr = 1'b0;
    @(negedge clk);
    chk("post_handoff_dv", dv, 0);
    chk("post_handoff_ready", b_ready, !serr_exp);
  endtask

  initial begin
    bv = 1'b1;
    #2;
    chk("rst_block_ready", b_ready, 1);
    chk("rst_strobes", {absorb, st_clr, rc_ce, rc_rst, round_en, dv}, 0);
    chk("rst_round_idx", ridx, 0);
    chk("rst_cnt", bcnt, 0);
    chk("rst_sync_err", serr, 0);
    bv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    send_msg(1, 0, 1'b0, -1);   // single-block message
    send_msg(3, 0, 1'b0, -1);   // three blocks, valid held
    send_msg(2, 10, 1'b0, -1);  // digest backpressure
    send_msg(6, 0, 1'b0, -1);   // counter saturation at width 2

    // Reset mid-ROUNDS aborts the message.
    begin
      exp_t e;
      e = '{kind: 1'b0, clear: exp_first, cnt: 2'd0, serr: 1'b0};
      sb.push_back(e);
      @(posedge clk); #1;
      bv = 1'b1;
      bl = 1'b1;
      wait_accept();
      @(posedge clk); #1;
      bv = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (round_en && ridx == 5'd12) break;
      end
      chk("reached_round12", ridx, 12);
      #1;
      rst = 1'b1;
      bv = 1'b1;
      #1;
      chk("midrst_round_en", round_en, 0);
      chk("midrst_round_idx", ridx, 0);
      chk("midrst_dv", dv, 0);
      chk("midrst_ready", b_ready, 1);
      chk("midrst_strobes", {absorb, st_clr, rc_ce, rc_rst}, 0);
      sb.delete();
      exp_first = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bv = 1'b0;
      bl = 1'b0;
      begin
        bit seen = 0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (dv) seen = 1;
        end
        chk("midrst_no_digest", seen, 0);
      end
    end

    send_msg(1, 0, 1'b0, -1);   // first block after reset clears state
    send_msg(1, 0, 1'b1, 5);    // sync fault at round 5

    @(posedge clk); #1;
    bv = 1'b1;
    bl = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fault_ready_low", b_ready, 0);
    end
    bv = 1'b0;
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/sha3_sponge_ctrl.md
SHA3_SPONGE_CTRL -- requirements
Module: sha3_sponge_ctrl

Interface
REQ-001 Parameter: BLOCK_CNT_W, default 8, width of the per-message absorbed-block counter.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 A_RST  in  1  reset, asynchronous, active-high.
REQ-004 BLOCK_VALID  in  1  upstream rate block presented.
REQ-005 BLOCK_LAST  in  1  presented block is the final padded block of the message; qualified by BLOCK_VALID.
REQ-006 BLOCK_READY  out  1  controller accepts a block this cycle.
REQ-007 RC_CE  out  1  clock enable to the round-constant counter.
REQ-008 RC_COUNTER_RESET  out  1  restarts the round-constant counter at round 0.
REQ-009 RC_WAIT  in  1  WAIT_FOR_NEW_MESSAGE returned by the round-constant counter.
REQ-010 STATE_CLEAR  out  1  datapath zeroes the 1600-bit state before the XOR in the same cycle.
REQ-011 ABSORB_EN  out  1  datapath XORs the input block into the state.
REQ-012 ROUND_EN  out  1  datapath applies one Keccak-f round using the current constant.
REQ-013 ROUND_IDX  out  5  current round number, 0..23.
REQ-014 MSG_BLOCK_CNT  out  BLOCK_CNT_W  blocks absorbed in the current message.
REQ-015 DIGEST_VALID  out  1  state holds the final digest.
REQ-016 DIGEST_READY  in  1  downstream takes the digest.
REQ-017 SYNC_ERR  out  1  sticky flag: round-constant counter out of step.

Function
REQ-018 The FSM SHALL have states IDLE, ROUNDS and SQUEEZE.
REQ-019 BLOCK_READY SHALL be 1 only in IDLE with SYNC_ERR=0.
REQ-020 Accept = BLOCK_VALID & BLOCK_READY. In an accept cycle, ABSORB_EN, RC_CE and RC_COUNTER_RESET SHALL be 1 (combinational), and the FSM SHALL go to ROUNDS with ROUND_IDX=0.
REQ-021 STATE_CLEAR SHALL equal accept & first_block. first_block is set at reset and on digest handoff, and cleared on any accept.
REQ-022 On accept, BLOCK_LAST SHALL be latched into last_flag.
- MSG_BLOCK_CNT becomes 1 if first_block=1, else increments.
- MSG_BLOCK_CNT saturates at all-ones.
REQ-023 In ROUNDS, ROUND_EN=1 and RC_CE=1 SHALL hold every cycle, and ROUND_IDX SHALL increment by 1 per cycle.
REQ-024 In ROUNDS with ROUND_IDX=23: the next state SHALL be SQUEEZE if last_flag=1, else IDLE; ROUND_IDX SHALL return to 0.
REQ-025 ROUNDS SHALL last exactly 24 cycles. An accept at cycle T gives ROUND_EN in cycles T+1..T+24.
REQ-026 The earliest next accept or DIGEST_VALID SHALL be T+25.
REQ-027 In SQUEEZE, DIGEST_VALID SHALL be 1 and held until DIGEST_READY=1. That cycle SHALL be the handoff: the FSM goes to IDLE, first_block=1, last_flag=0.
REQ-028 BLOCK_VALID SHALL be ignored outside IDLE. DIGEST_READY SHALL be ignored outside SQUEEZE.
REQ-029 RC_CE, RC_COUNTER_RESET, ABSORB_EN, STATE_CLEAR and ROUND_EN SHALL be 0 in IDLE without accept, and in SQUEEZE.
REQ-030 SYNC_ERR SHALL be set on either condition below, and stays set until A_RST:
- RC_WAIT=1 in any ROUNDS cycle with ROUND_IDX>=1;
- RC_WAIT=0 in the first cycle after leaving ROUNDS.
REQ-031 While SYNC_ERR=1, the FSM SHALL still complete the current ROUNDS/SQUEEZE sequence but accept no further blocks.
REQ-032 A BLOCK_LAST block that is also the first block (single-block message) SHALL assert STATE_CLEAR and reach SQUEEZE after 24 rounds.

Reset
REQ-033 On A_RST=1, regardless of CLK, the block SHALL enter IDLE with ROUND_IDX=0, MSG_BLOCK_CNT=0, SYNC_ERR=0, first_block=1 and last_flag=0.
REQ-034 During reset, DIGEST_VALID and all strobes SHALL be 0, and BLOCK_READY SHALL be 1.
REQ-035 Reset asserted mid-ROUNDS or mid-SQUEEZE SHALL abort the message with no digest.
REQ-036 After release, the first accepted block SHALL assert STATE_CLEAR.

Verification
REQ-037 Single-block message: BLOCK_VALID=BLOCK_LAST=1 accepted at T.
- T: STATE_CLEAR=ABSORB_EN=RC_COUNTER_RESET=1.
- T+1..T+24: ROUND_EN=1, ROUND_IDX 0..23.
- T+25: DIGEST_VALID=1, MSG_BLOCK_CNT=1, SYNC_ERR=0 against the real counter.
REQ-038 Three-block message with BLOCK_VALID held high:
- accepts at T, T+25, T+50;
- STATE_CLEAR only at T;
- DIGEST_VALID at T+75, MSG_BLOCK_CNT=3.
REQ-039 Digest backpressure: DIGEST_READY low for 10 cycles.
- DIGEST_VALID stays 1 and BLOCK_READY stays 0 throughout.
- On handoff: IDLE next cycle, and the next accept asserts STATE_CLEAR.
REQ-040 Sync fault: force RC_WAIT=1 at ROUND_IDX=5 → SYNC_ERR=1 next cycle; the sequence completes; BLOCK_READY stays 0 afterwards.
REQ-041 Reset mid-operation: A_RST pulsed at ROUND_IDX=12 → immediate IDLE, ROUND_IDX=0, no DIGEST_VALID, BLOCK_READY=1.
REQ-042 Saturation: with BLOCK_CNT_W=2, five non-last blocks then one last block → MSG_BLOCK_CNT stays at 3.
